// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder, one full-adder cell plus a carry flop.
// Operands are captured on start, then added LSB first, one bit per clock.
// {cout,sum} = a + b + cin; done strobes for one cycle when sum/cout update.
// Optional feature macro: SERIAL_ADDER_OVF_EN enables the signed-overflow
// output; without it ovf is tied to 0 and the MSB carry flop is not built.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             carry;
    logic [CW-1:0]    count;
    logic             bit_s;
    logic             bit_c;
    logic             last;

    // Single full-adder cell reused every SHIFT cycle on the operand LSBs.
    always_comb begin
        bit_s = a_sr[0] ^ b_sr[0] ^ carry;
        bit_c = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    end

    assign last = (count == CW'(WIDTH - 1));

    // Control FSM and datapath; busy/done are flops so outputs stay registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            carry <= 1'b0;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        count <= '0;
                        s_sr  <= '0;
                        state <= S_SHIFT;
                        busy  <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    s_sr  <= {bit_s, s_sr[WIDTH-1:1]};
                    carry <= bit_c;
                    count <= count + 1'b1;
                    if (last) begin
                        // Result is taken from the shift register's next value
                        // so it lands on the same edge as the final bit.
                        sum   <= {bit_s, s_sr[WIDTH-1:1]};
                        cout  <= bit_c;
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic msb_carry;

    // Capture the carry into the MSB one bit early, then compare it with the
    // carry out of the MSB on the final bit to flag signed overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            msb_carry <= 1'b0;
            ovf       <= 1'b0;
        end else if (state == S_SHIFT) begin
            if (count == CW'(WIDTH - 2)) msb_carry <= bit_c;
            if (last) ovf <= msb_carry ^ bit_c;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: transaction-level reference model plus directed
// literal checks, held-start throughput, mid-operation reset and random traffic.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         cin   = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int vectors    = 0;
    int miscompares = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: an accepted operation is busy for W+1 edges after the
    // accepting edge, publishes its result after W edges, and the block is
    // free again W+2 edges after acceptance.
    bit           m_valid  = 1'b0;
    bit           m_active = 1'b0;
    int           m_k      = 0;
    logic [W-1:0] m_sum    = '0;
    logic         m_cout   = 1'b0;
    logic         m_ovf    = 1'b0;
    logic [W-1:0] p_sum    = '0;
    logic         p_cout   = 1'b0;
    logic         p_ovf    = 1'b0;

    function automatic logic [W+1:0] golden(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        longint t, sx, sy, st;
        logic [W+1:0] r;
        t  = longint'(x) + longint'(y) + longint'(c);
        sx = x[W-1] ? longint'(x) - (longint'(1) <<< W) : longint'(x);
        sy = y[W-1] ? longint'(y) - (longint'(1) <<< W) : longint'(y);
        st = sx + sy + longint'(c);
        r[W:0]  = t[W:0];
        r[W+1]  = (st > (longint'(1) <<< (W-1)) - 1) || (st < -(longint'(1) <<< (W-1)));
        return r;
    endfunction

    always @(posedge clk) begin
        logic [W+1:0] g;
        if (!rst_n) begin
            m_valid  <= 1'b1;
            m_active <= 1'b0;
            m_sum    <= '0;
            m_cout   <= 1'b0;
            m_ovf    <= 1'b0;
        end else if (m_active) begin
            m_k <= m_k + 1;
            if (m_k + 1 == W) begin
                m_sum  <= p_sum;
                m_cout <= p_cout;
                m_ovf  <= p_ovf;
            end
            if (m_k + 1 == W + 1) m_active <= 1'b0;
        end else if (start) begin
            g = golden(a, b, cin);
            m_active <= 1'b1;
            m_k      <= 0;
            p_sum    <= g[W-1:0];
            p_cout   <= g[W];
`ifdef SERIAL_ADDER_OVF_EN
            p_ovf    <= g[W+1];
`else
            p_ovf    <= 1'b0;
`endif
        end
    end

    // Every cycle, outputs are compared with the model away from the clock edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model busy", 32'(busy), 32'(m_active));
            check("model done", 32'(done), 32'(m_active && m_k == W));
            check("model sum",  32'(sum),  32'(m_sum));
            check("model cout", 32'(cout), 32'(m_cout));
            check("model ovf",  32'(ovf),  32'(m_ovf));
        end
    end

    // One directed addition from an idle negedge; operands are scrambled while
    // busy to show the in-flight result is unaffected.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input logic [W-1:0] es, input logic ec, input logic eo, input string tag);
        int n, busy_n, done_at;
        logic [W-1:0] got_s;
        logic got_c, got_o;
        got_s = '0; got_c = 1'b0; got_o = 1'b0;
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1; busy_n = 0; done_at = -1;
        while (n < 40) begin
            if (busy) busy_n++;
            if (done) begin
                done_at = n; got_s = sum; got_c = cout; got_o = ovf;
            end
            if (!busy) break;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 32'(done_at), 32'(W + 1));
        check({tag, " busy cycles"}, 32'(busy_n), 32'(W + 1));
        check({tag, " sum"}, 32'(got_s), 32'(es));
        check({tag, " cout"}, 32'(got_c), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, " ovf"}, 32'(got_o), 32'(eo));
`else
        check({tag, " ovf"}, 32'(got_o), 32'(0));
`endif
    endtask

    initial begin
        int cyc, last_done, done_cnt;
        bit saw;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'(0));
        check("reset done", 32'(done), 32'(0));
        check("reset sum",  32'(sum),  32'(0));
        check("reset cout", 32'(cout), 32'(0));
        check("reset ovf",  32'(ovf),  32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "zero");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ff+1");
        run_op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, "a5+5a+1");
        run_op(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, "3c+0f");
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "7f+1");

        // start held high: results every W+2 cycles, operands disturbed mid-SHIFT
        start = 1'b1; cyc = 0; last_done = -1; done_cnt = 0;
        repeat (45) begin
            if (done) begin
                check("held sum", 32'(sum), 32'h46);
                if (last_done >= 0) check("held period", 32'(cyc - last_done), 32'(W + 2));
                last_done = cyc;
                done_cnt++;
            end
            if (!busy) begin
                a = 8'h12; b = 8'h34; cin = 1'b0;
            end else begin
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        check("held done count", 32'(done_cnt >= 4), 32'(1));
        start = 1'b0;
        repeat (12) @(negedge clk);

        // reset sampled on SHIFT edge 4 aborts the operation
        a = 8'hC3; b = 8'h99; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort busy", 32'(busy), 32'(0));
        check("abort done", 32'(done), 32'(0));
        check("abort sum",  32'(sum),  32'(0));
        check("abort cout", 32'(cout), 32'(0));
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done) saw = 1'b1;
        end
        check("abort no done", 32'(saw), 32'(0));
        run_op(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, "after abort");

        // random traffic with occasional resets, checked by the model
        repeat (600) begin
            start = ($urandom % 3) == 0;
            a     = W'($urandom);
            b     = W'($urandom);
            cin   = 1'($urandom);
            rst_n = ($urandom % 150) != 0;
            @(negedge clk);
        end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (15) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
